// File: rtl/wb_pkg.sv
// wb_pkg: shared types and widths for the writeback arbiter slice.
//   REG_ADDR_W / DATA_W : register-file address and data widths
//   wb_entry_t          : one buffered load-stream write {valid, addr, data}
//   wb_sel_e            : which source owns the register-file port this cycle
package wb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_ALU,
        SEL_FIFO
    } wb_sel_e;

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: circular buffer of wb_entry_t for the load/multi-cycle stream.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   i_push, i_push_entry write one entry at the tail (caller ensures !o_full)
//   i_pop                drop the head entry (caller ensures !o_empty)
//   i_kill_en/i_kill_addr clear the valid bit of every stored entry with that addr
//   o_head               current head entry
//   o_full, o_empty, o_count occupancy status
//   o_rd_ptr, o_entries  head pointer and every slot, for the bypass search
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  wb_entry_t                i_push_entry,
    input  logic                     i_pop,
    input  logic                     i_kill_en,
    input  logic [REG_ADDR_W-1:0]    i_kill_addr,
    output wb_entry_t                o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic [$clog2(DEPTH)-1:0] o_rd_ptr,
    output wb_entry_t [DEPTH-1:0]    o_entries
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // One register per slot. A push into a slot takes precedence over a kill
    // in the same cycle: the pushed entry is younger than the killing write.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            wb_entry_t r_slot;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_slot <= '0;
                end else if (i_push && (r_wr_ptr == PTR_W'(gi))) begin
                    r_slot <= i_push_entry;
                end else if (i_kill_en && (r_slot.addr == i_kill_addr)) begin
                    r_slot.valid <= 1'b0;
                end
            end
            assign o_entries[gi] = r_slot;
        end
    endgenerate

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (i_push && !i_pop)      r_count <= r_count + 1'b1;
            else if (!i_push && i_pop) r_count <= r_count - 1'b1;
        end
    end

    assign o_head   = o_entries[r_rd_ptr];
    assign o_full   = (r_count == CNT_W'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign o_count  = r_count;
    assign o_rd_ptr = r_rd_ptr;

endmodule

// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter: owns the register-file write port. Merges the ALU result
// stream (single cycle, highest priority) with the buffered load stream,
// drops r0 writes, kills buffered writes overtaken by a newer ALU write and
// raises hold_req when the buffered stream starves.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   alu_valid/alu_addr/alu_data      ALU result (no backpressure)
//   ls_valid/ls_ready/ls_addr/ls_data load-stream offer (valid/ready)
//   rf_we/rf_waddr/rf_wdata          registered register-file write port
//   hold_req                         asks upstream to suppress alu_valid
//   byp_addr/byp_hit/byp_data        bypass lookup of pending writes
//   fifo_count                       load buffer occupancy
// Configuration: define WB_BYPASS_EN to build the bypass lookup; otherwise
// byp_hit/byp_data are tied to zero and byp_addr is ignored.
module wb_write_arbiter
    import wb_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         alu_valid,
    input  logic [4:0]                   alu_addr,
    input  logic [31:0]                  alu_data,
    input  logic                         ls_valid,
    output logic                         ls_ready,
    input  logic [4:0]                   ls_addr,
    input  logic [31:0]                  ls_data,
    output logic                         rf_we,
    output logic [4:0]                   rf_waddr,
    output logic [31:0]                  rf_wdata,
    output logic                         hold_req,
    input  logic [4:0]                   byp_addr,
    output logic                         byp_hit,
    output logic [31:0]                  byp_data,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    wb_entry_t                  w_head;
    wb_entry_t                  w_push_entry;
    wb_entry_t [FIFO_DEPTH-1:0] w_entries;
    logic                       w_full;
    logic                       w_empty;
    logic [CNT_W-1:0]           w_count;
    logic [PTR_W-1:0]           w_rd_ptr;
    logic                       w_push;
    logic                       w_pop;
    logic                       w_alu_win;
    wb_sel_e                    w_sel;

    logic                       r_rf_we;
    logic [REG_ADDR_W-1:0]      r_rf_waddr;
    logic [DATA_W-1:0]          r_rf_wdata;
    logic [STV_W-1:0]           r_starve;

    // ls_ready depends on full only; a same-cycle pop does not free a slot.
    assign ls_ready     = !w_full;
    assign w_push       = ls_valid && !w_full;
    assign w_push_entry = '{valid: 1'b1, addr: ls_addr, data: ls_data};

    // Any alu_valid (including an r0 write that is discarded) blocks the pop.
    assign w_alu_win = alu_valid && (alu_addr != '0);
    assign w_pop     = !alu_valid && !w_empty;

    always_comb begin
        w_sel = SEL_NONE;
        if (w_alu_win) begin
            w_sel = SEL_ALU;
        end else if (w_pop && w_head.valid && (w_head.addr != '0)) begin
            w_sel = SEL_FIFO;
        end
    end

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_pop        (w_pop),
        .i_kill_en    (w_alu_win),
        .i_kill_addr  (alu_addr),
        .o_head       (w_head),
        .o_full       (w_full),
        .o_empty      (w_empty),
        .o_count      (w_count),
        .o_rd_ptr     (w_rd_ptr),
        .o_entries    (w_entries)
    );

    // Output stage: address/data hold their last value between writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
        end else begin
            r_rf_we <= (w_sel != SEL_NONE);
            case (w_sel)
                SEL_ALU: begin
                    r_rf_waddr <= alu_addr;
                    r_rf_wdata <= alu_data;
                end
                SEL_FIFO: begin
                    r_rf_waddr <= w_head.addr;
                    r_rf_wdata <= w_head.data;
                end
                default: ;
            endcase
        end
    end

    // Starvation counter saturates at the limit so hold_req stays asserted
    // for as long as the ALU keeps the port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve <= '0;
        end else if (w_empty || w_pop) begin
            r_starve <= '0;
        end else if (r_starve != STV_W'(STARVE_LIMIT)) begin
            r_starve <= r_starve + 1'b1;
        end
    end

    assign hold_req   = (r_starve >= STV_W'(STARVE_LIMIT));
    assign rf_we      = r_rf_we;
    assign rf_waddr   = r_rf_waddr;
    assign rf_wdata   = r_rf_wdata;
    assign fifo_count = w_count;

`ifdef WB_BYPASS_EN
    // Walk oldest to youngest so the youngest matching entry wins; the
    // output stage overrides the buffer.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx      = '0;
        byp_hit  = 1'b0;
        byp_data = '0;
        if (byp_addr != '0) begin
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                idx = w_rd_ptr + PTR_W'(k);
                if ((CNT_W'(k) < w_count) && w_entries[idx].valid &&
                    (w_entries[idx].addr == byp_addr)) begin
                    byp_hit  = 1'b1;
                    byp_data = w_entries[idx].data;
                end
            end
            if (r_rf_we && (r_rf_waddr == byp_addr)) begin
                byp_hit  = 1'b1;
                byp_data = r_rf_wdata;
            end
        end
    end
`else
    assign byp_hit  = 1'b0;
    assign byp_data = '0;
    wire w_unused_byp = ^{byp_addr, w_entries, w_rd_ptr};
`endif

endmodule

// File: tb/tb_wb_write_arbiter.sv
module tb_wb_write_arbiter;

    localparam int FD = 4;
    localparam int SL = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        alu_valid, ls_valid;
    logic [4:0]  alu_addr, ls_addr, byp_addr;
    logic [31:0] alu_data, ls_data;
    logic        ls_ready, rf_we, hold_req, byp_hit;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, byp_data;
    logic [$clog2(FD):0] fifo_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wb_write_arbiter #(.FIFO_DEPTH(FD), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data),
        .ls_valid(ls_valid), .ls_ready(ls_ready), .ls_addr(ls_addr), .ls_data(ls_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .hold_req(hold_req),
        .byp_addr(byp_addr), .byp_hit(byp_hit), .byp_data(byp_data),
        .fifo_count(fifo_count)
    );

    // Advance one cycle; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
        ls_valid  = 1'b0; ls_addr  = '0; ls_data  = '0;
        byp_addr  = '0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_rf_we got %0b want 0", rf_we); end
        n_checks++; if (rf_waddr !== 5'd0) begin n_fail++; $display("FAIL reset_rf_waddr got %0d want 0", rf_waddr); end
        n_checks++; if (rf_wdata !== 32'd0) begin n_fail++; $display("FAIL reset_rf_wdata got %h want 0", rf_wdata); end
        n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", fifo_count); end
        n_checks++; if (ls_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ls_ready got %0b want 1", ls_ready); end
        n_checks++; if (hold_req !== 1'b0) begin n_fail++; $display("FAIL reset_hold got %0b want 0", hold_req); end
        n_checks++; if (byp_hit !== 1'b0 || byp_data !== 32'd0) begin n_fail++; $display("FAIL reset_bypass got %0b/%h want 0/0", byp_hit, byp_data); end
        step(); step();
        rst_n = 1'b1;
        step();
        $display("reset: released, rf_we=%0b count=%0d", rf_we, fifo_count);
    endtask

    task automatic test_alu_single();
        alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'h12345678;
        step();
        idle_inputs();
        $display("alu: addr=5 -> rf_we=%0b waddr=%0d wdata=%h", rf_we, rf_waddr, rf_wdata);
        n_checks++; if (rf_we !== 1'b1) begin n_fail++; $display("FAIL alu_we got %0b want 1", rf_we); end
        n_checks++; if (rf_waddr !== 5'd5) begin n_fail++; $display("FAIL alu_waddr got %0d want 5", rf_waddr); end
        n_checks++; if (rf_wdata !== 32'h12345678) begin n_fail++; $display("FAIL alu_wdata got %h want 12345678", rf_wdata); end
        step();
        n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL alu_we_pulse got %0b want 0", rf_we); end
        n_checks++; if (rf_waddr !== 5'd5 || rf_wdata !== 32'h12345678) begin n_fail++; $display("FAIL alu_hold got %0d/%h want 5/12345678", rf_waddr, rf_wdata); end
    endtask

    task automatic test_starve_drain();
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (ls_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready[%0d] got %0b want 1", i, ls_ready); end
            alu_valid = 1'b1; alu_addr = 5'(8 + i); alu_data = 32'hA000 + i;
            ls_valid  = 1'b1; ls_addr  = 5'(i + 1); ls_data  = 32'h100 + 32'(i + 1);
            step();
            $display("fill: push addr=%0d count=%0d", i + 1, fifo_count);
        end
        ls_valid = 1'b0;
        n_checks++; if (ls_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got %0b want 0", ls_ready); end
        n_checks++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL full_count got %0d want 4", fifo_count); end
        n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd11) begin n_fail++; $display("FAIL fill_alu got %0b/%0d want 1/11", rf_we, rf_waddr); end
        for (int c = 4; c <= 9; c++) begin
            if (c == 8) begin
                n_checks++; if (hold_req !== 1'b0) begin n_fail++; $display("FAIL hold_early got %0b want 0", hold_req); end
            end
            if (c == 9) begin
                n_checks++; if (hold_req !== 1'b1) begin n_fail++; $display("FAIL hold_rise got %0b want 1", hold_req); end
            end
            alu_addr = 5'(c + 8); alu_data = 32'hB000 + 32'(c);
            step();
            $display("starve: cycle %0d hold=%0d", c + 1, hold_req);
        end
        n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd17) begin n_fail++; $display("FAIL alu_during_hold got %0b/%0d want 1/17", rf_we, rf_waddr); end
        n_checks++; if (hold_req !== 1'b1) begin n_fail++; $display("FAIL hold_kept got %0b want 1", hold_req); end
        alu_valid = 1'b0;
        for (int j = 0; j < 4; j++) begin
            step();
            $display("drain: rf_we=%0b waddr=%0d wdata=%h count=%0d", rf_we, rf_waddr, rf_wdata, fifo_count);
            n_checks++;
            if (rf_we !== 1'b1 || rf_waddr !== 5'(j + 1) || rf_wdata !== 32'h100 + 32'(j + 1)) begin
                n_fail++; $display("FAIL drain[%0d] got %0b/%0d/%h want 1/%0d/%h", j, rf_we, rf_waddr, rf_wdata, j + 1, 32'h100 + 32'(j + 1));
            end
            n_checks++; if (fifo_count !== 3'(3 - j)) begin n_fail++; $display("FAIL drain_count[%0d] got %0d want %0d", j, fifo_count, 3 - j); end
            if (j == 0) begin
                n_checks++; if (hold_req !== 1'b0 || ls_ready !== 1'b1) begin n_fail++; $display("FAIL drain_hold_ready got %0b/%0b want 0/1", hold_req, ls_ready); end
            end
        end
        step();
        n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL drain_done_we got %0b want 0", rf_we); end
    endtask

    task automatic test_kill();
        ls_valid = 1'b1; ls_addr = 5'd7; ls_data = 32'hAAAA;
        step();
        ls_valid = 1'b0;
        alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'hBBBB;
        step();
        alu_valid = 1'b0;
        $display("kill: rf_we=%0b waddr=%0d wdata=%h count=%0d", rf_we, rf_waddr, rf_wdata, fifo_count);
        n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'hBBBB) begin n_fail++; $display("FAIL kill_alu got %0b/%0d/%h want 1/7/bbbb", rf_we, rf_waddr, rf_wdata); end
        n_checks++; if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL kill_count got %0d want 1", fifo_count); end
        step();
        n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL kill_silent got %0b/%h want 0", rf_we, rf_wdata); end
        n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL kill_popped got %0d want 0", fifo_count); end
        n_checks++; if (rf_wdata !== 32'hBBBB) begin n_fail++; $display("FAIL kill_data_hold got %h want bbbb", rf_wdata); end
    endtask

    task automatic test_r0();
        ls_valid = 1'b1; ls_addr = 5'd0; ls_data = 32'h55;
        step();
        ls_valid = 1'b0;
        alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'h66;
        step();
        alu_valid = 1'b0;
        $display("r0: rf_we=%0b count=%0d", rf_we, fifo_count);
        n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL r0_alu_we got %0b want 0", rf_we); end
        n_checks++; if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL r0_no_pop got %0d want 1", fifo_count); end
        step();
        n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL r0_load_we got %0b want 0", rf_we); end
        n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL r0_consumed got %0d want 0", fifo_count); end
    endtask

    task automatic test_bypass();
        ls_valid = 1'b1; ls_addr = 5'd3; ls_data = 32'h11;
        step();
        ls_data = 32'h22;
        alu_valid = 1'b1; alu_addr = 5'd9; alu_data = 32'h99;
        step();
        ls_valid = 1'b0; alu_valid = 1'b0;
        byp_addr = 5'd3; #1;
        $display("bypass: addr=3 hit=%0b data=%h count=%0d", byp_hit, byp_data, fifo_count);
`ifdef WB_BYPASS_EN
        n_checks++; if (byp_hit !== 1'b1 || byp_data !== 32'h22) begin n_fail++; $display("FAIL byp_youngest got %0b/%h want 1/22", byp_hit, byp_data); end
        byp_addr = 5'd9; #1;
        n_checks++; if (byp_hit !== 1'b1 || byp_data !== 32'h99) begin n_fail++; $display("FAIL byp_outstage got %0b/%h want 1/99", byp_hit, byp_data); end
        byp_addr = 5'd0; #1;
        n_checks++; if (byp_hit !== 1'b0) begin n_fail++; $display("FAIL byp_r0 got %0b want 0", byp_hit); end
`else
        n_checks++; if (byp_hit !== 1'b0 || byp_data !== 32'd0) begin n_fail++; $display("FAIL byp_disabled got %0b/%h want 0/0", byp_hit, byp_data); end
`endif
        byp_addr = 5'd0;
        @(posedge clk); #1;
        step(); step();
        n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL byp_drain got %0d want 0", fifo_count); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            alu_valid = 1'b1; alu_addr = 5'(10 + i); alu_data = 32'hC0 + i;
            ls_valid  = 1'b1; ls_addr  = 5'(20 + i); ls_data  = 32'hD0 + i;
            step();
        end
        idle_inputs();
        n_checks++; if (fifo_count !== 3'd3) begin n_fail++; $display("FAIL mid_count got %0d want 3", fifo_count); end
        #2 rst_n = 1'b0;
        #1;
        $display("mid reset: rf_we=%0b count=%0d", rf_we, fifo_count);
        n_checks++; if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin n_fail++; $display("FAIL mid_rf got %0b/%0d/%h want 0/0/0", rf_we, rf_waddr, rf_wdata); end
        n_checks++; if (fifo_count !== 3'd0 || ls_ready !== 1'b1 || hold_req !== 1'b0) begin n_fail++; $display("FAIL mid_state got %0d/%0b/%0b want 0/1/0", fifo_count, ls_ready, hold_req); end
        step(); step();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            n_checks++; if (rf_we !== 1'b0 || fifo_count !== 3'd0) begin n_fail++; $display("FAIL post_reset[%0d] got %0b/%0d want 0/0", k, rf_we, fifo_count); end
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_alu_single();
        test_starve_drain();
        test_kill();
        test_r0();
        test_bypass();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_write_arbiter.md
# wb_write_arbiter

Writeback arbiter that owns the single write port of the 32x32 register file. It merges a single-cycle ALU result stream (no backpressure, highest priority) with a load/multi-cycle result stream (valid/ready, buffered in a small FIFO). It drops writes to r0, kills stale buffered writes overtaken by a newer ALU write, and raises a hold request when the buffered stream starves. It sits between the execute/memory stages and the register file, driving its write-enable, write-address and write-data inputs.

## Interface
- FIFO_DEPTH, 4, load-stream buffer entries; power of two, 2..16
- STARVE_LIMIT, 8, cycles a non-empty FIFO may go unserved before hold_req asserts
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; asynchronous assert, active-low; one clock domain only
- alu_valid  in  1  ALU result present this cycle
- alu_addr  in  5  ALU destination register
- alu_data  in  32  ALU result
- ls_valid  in  1  load/multi-cycle result offered
- ls_ready  out  1  FIFO can accept; equals !full
- ls_addr  in  5  load destination register
- ls_data  in  32  load result
- rf_we  out  1  register-file write enable (registered)
- rf_waddr  out  5  register-file write address (registered)
- rf_wdata  out  32  register-file write data (registered)
- hold_req  out  1  asks the pipeline to suppress alu_valid next cycle
- byp_addr  in  5  bypass lookup address
- byp_hit  out  1  a pending write to byp_addr exists
- byp_data  out  32  value of the youngest pending write to byp_addr
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

## Operation
- Push: an entry {valid=1, addr, data} is written into the FIFO when ls_valid && ls_ready. ls_ready depends only on full; a pop in the same cycle does not free a slot early.
- Selection each cycle, in priority order:
  - alu_valid && alu_addr!=0: the ALU write wins.
  - alu_valid && alu_addr==0: the ALU write is discarded. The port is not given to the FIFO that cycle.
  - Otherwise, FIFO non-empty: pop the head. If the head is valid and its addr!=0, it becomes the write. An invalid or r0 head is popped silently.
- Kill: an accepted ALU write with addr A clears the valid bit of every FIFO entry with addr A. An entry pushed in the same cycle with addr A is not killed, because it is younger.
- Starvation counter:
  - Increments each cycle the FIFO is non-empty and no pop occurs.
  - Clears on any pop or when the FIFO is empty.
  - hold_req = (counter >= STARVE_LIMIT).
  - If alu_valid arrives while hold_req is high, the ALU still wins and the counter keeps counting.
- Ordering contract: the upstream scoreboard guarantees that load-stream writes to one register arrive in program order.

## Timing
- ALU latency is 1 cycle: a write selected in cycle N appears on rf_* in cycle N+1.
- Load latency is at least 2 cycles. An entry pushed in cycle N is poppable from N+1 and appears on rf_* at N+2 or later.
- rf_we is high for exactly one cycle per write. rf_waddr and rf_wdata hold their last value when rf_we=0.
- Reset values:
  - rf_we=0, rf_waddr=0, rf_wdata=0
  - FIFO empty, all valid bits 0, fifo_count=0
  - ls_ready=1, hold_req=0, starvation counter 0
  - byp_hit=0, byp_data=0
- Reset asserted mid-operation discards all buffered entries; no partial write is issued.
- Full FIFO with ls_valid high: ls_ready=0. The source must hold its offer until ready.
- Simultaneous push and pop on a non-empty FIFO: occupancy is unchanged and pointers wrap modulo FIFO_DEPTH.

## Configuration
- WB_BYPASS_EN defined: the bypass lookup is combinational from byp_addr, with this priority:
  - Registered output stage, when rf_we && rf_waddr==byp_addr.
  - Otherwise the youngest valid FIFO entry matching byp_addr.
  - byp_addr==0 never hits.
- WB_BYPASS_EN undefined: byp_hit=0 and byp_data=0 are constant, no compare logic is built, and byp_addr is ignored.

## Structure
- Package wb_pkg holds:
  - REG_ADDR_W=5 and DATA_W=32.
  - wb_entry_t, a packed struct {valid, addr, data}.
  - wb_sel_e, the selection enum {SEL_NONE, SEL_ALU, SEL_FIFO}.
- Sub-module wb_fifo is the circular buffer of wb_entry_t. It provides push/pop, full/empty and count, plus a per-entry kill-by-address port and parallel entry visibility for the bypass search. The arbiter, starvation counter and output registers live in wb_write_arbiter.

## Test plan
- Reset, then alu_valid=1, addr=5, data=0x12345678 in one cycle -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x12345678; the cycle after, rf_we=0.
- Push 4 load entries (addrs 1..4) while ALU writes continuously to addrs 8+ -> after the 4th push ls_ready=0 and fifo_count=4; hold_req rises STARVE_LIMIT=8 cycles after the first unserved cycle; with alu_valid dropped, entries drain in order 1,2,3,4 on consecutive cycles.
- Push load addr=7 data=0xAAAA, then ALU write addr=7 data=0xBBBB before it drains -> rf_* shows 7/0xBBBB only, the FIFO entry is popped silently, and register 7 is never written with 0xAAAA.
- ALU addr=0 and load addr=0 -> rf_we stays 0, and the load entry is consumed (fifo_count decrements).
- With WB_BYPASS_EN: buffer loads addr=3 data=0x11 then addr=3 data=0x22, with byp_addr=3 -> byp_hit=1, byp_data=0x22; with byp_addr=0 -> byp_hit=0.
- Assert rst_n=0 with 3 entries buffered -> all outputs immediately at reset values; after release no rf_we pulse occurs.
